// File: rtl/video_timing_gen.sv
// Parametrised video timing generator: x/y raster counters, a
// latency-matched sync/blank/de delay line, and frame/vblank events.
module video_timing_gen #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_PULSE  = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE  = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int H_POL         = 0,
  parameter int V_POL         = 0,
  parameter int PIPE_DELAY    = 2,
  parameter int CNT_W         = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             h_sync,
  output logic             v_sync,
  output logic             blank,
  output logic             de,
  output logic             frame_start,
  output logic             vblank_start,
  output logic [15:0]      frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT_PORCH
                         + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT_PORCH
                         + V_SYNC_PULSE + V_BACK_PORCH;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_VBL  = CNT_W'(V_VISIBLE - 1);

  localparam logic [CNT_W-1:0] HS_BEG =
    CNT_W'(H_VISIBLE + H_FRONT_PORCH);
  localparam logic [CNT_W-1:0] HS_END =
    CNT_W'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [CNT_W-1:0] VS_BEG =
    CNT_W'(V_VISIBLE + V_FRONT_PORCH);
  localparam logic [CNT_W-1:0] VS_END =
    CNT_W'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE);

  localparam logic HP = 1'(H_POL);
  localparam logic VP = 1'(V_POL);

  // Delay stage bit layout: {hs, vs, vis}; all-zero is inactive.
  logic [PIPE_DELAY-1:0][2:0] pipe;
  logic [2:0]                 raw;
  logic [2:0]                 tap;

  logic line_end;
  logic frame_wrap;
  logic vbl_hit;
  logic [15:0] frame_q;

  // Raw decode of the coordinate currently on x/y.
  always_comb begin
    raw    = '0;
    raw[2] = (x >= HS_BEG) && (x < HS_END);
    raw[1] = (y >= VS_BEG) && (y < VS_END);
    raw[0] = (x < H_VIS) && (y < V_VIS);
  end

  assign line_end   = en && (x == H_LAST);
  assign frame_wrap = line_end && (y == V_LAST);
  assign vbl_hit    = line_end && (y == V_VBL);

  // Raster counters: x per enabled pixel, y per line wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == H_LAST) begin
        x <= '0;
        if (y == V_LAST) y <= '0;
        else             y <= y + CNT_W'(1);
      end else begin
        x <= x + CNT_W'(1);
      end
    end
  end

  // Shift the decode through the delay line on enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else if (en) begin
      pipe[0] <= raw;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Events land in the same cycle x/y first show the target point;
  // they are cleared on every other cycle, enabled or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_q      <= '0;
    end else begin
      frame_start  <= frame_wrap;
      vblank_start <= vbl_hit;
      frame_q      <= frame_q + 16'(frame_wrap);
    end
  end

  assign tap       = pipe[PIPE_DELAY-1];
  assign h_sync    = tap[2] ? HP : ~HP;
  assign v_sync    = tap[1] ? VP : ~VP;
  assign blank     = ~tap[0];
  assign de        = tap[0];
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: a default-size instance for
// line timing and two small instances for frame-level events.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  logic [10:0] m_x, m_y;
  logic m_hs, m_vs, m_bl, m_de, m_fs, m_vb;
  logic [15:0] m_fc;

  logic [4:0] t_x, t_y;
  logic t_hs, t_vs, t_bl, t_de, t_fs, t_vb;
  logic [15:0] t_fc;

  logic [4:0] p_x, p_y;
  logic p_hs, p_vs, p_bl, p_de, p_fs, p_vb;
  logic [15:0] p_fc;

  video_timing_gen dut_m (
    .clk(clk), .rst(rst), .en(en),
    .x(m_x), .y(m_y),
    .h_sync(m_hs), .v_sync(m_vs),
    .blank(m_bl), .de(m_de),
    .frame_start(m_fs), .vblank_start(m_vb),
    .frame_cnt(m_fc)
  );

  // Tiny raster: 12 x 8 totals, 96 clocks per frame, delay 3.
  video_timing_gen #(
    .H_VISIBLE(6), .H_FRONT_PORCH(2),
    .H_SYNC_PULSE(3), .H_BACK_PORCH(1),
    .V_VISIBLE(4), .V_FRONT_PORCH(1),
    .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
    .PIPE_DELAY(3), .CNT_W(5)
  ) dut_t (
    .clk(clk), .rst(rst), .en(en),
    .x(t_x), .y(t_y),
    .h_sync(t_hs), .v_sync(t_vs),
    .blank(t_bl), .de(t_de),
    .frame_start(t_fs), .vblank_start(t_vb),
    .frame_cnt(t_fc)
  );

  video_timing_gen #(
    .H_VISIBLE(6), .H_FRONT_PORCH(2),
    .H_SYNC_PULSE(3), .H_BACK_PORCH(1),
    .V_VISIBLE(4), .V_FRONT_PORCH(1),
    .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
    .H_POL(1), .V_POL(1),
    .PIPE_DELAY(3), .CNT_W(5)
  ) dut_p (
    .clk(clk), .rst(rst), .en(en),
    .x(p_x), .y(p_y),
    .h_sync(p_hs), .v_sync(p_vs),
    .blank(p_bl), .de(p_de),
    .frame_start(p_fs), .vblank_start(p_vb),
    .frame_cnt(p_fc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive at the falling edge, sample at the next falling edge.
  task automatic step(input logic r, input logic e);
    rst = r;
    en  = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic r;
    logic e;
    int   x;
    int   y;
    logic bl;
    logic fs;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int fs_k, vb_k, vb_n, vs_n, vs_f, pvs_n;
    int n, fs_n, hold_bad, pos_bad;
    int hn, hf, hl, den, rise, fall;
    logic pb, ph, pv, seen;

    tbl[0] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1, 0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 2, 0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 3, 0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b0};

    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].r, tbl[i].e);
      chk($sformatf("v%0d_x", i), t_x, tbl[i].x);
      chk($sformatf("v%0d_y", i), t_y, tbl[i].y);
      chk($sformatf("v%0d_blank", i), t_bl, tbl[i].bl);
      chk($sformatf("v%0d_de", i), t_de, !tbl[i].bl);
      chk($sformatf("v%0d_fs", i), t_fs, tbl[i].fs);
      chk($sformatf("v%0d_phs", i), p_hs, 0);
    end

    // Full tiny frame with en held high.
    step(1'b1, 1'b0);
    fs_k = 0; vb_k = 0; vb_n = 0;
    vs_n = 0; vs_f = 0; pvs_n = 0;
    for (int k = 1; k <= 200; k++) begin
      step(1'b0, 1'b1);
      if (t_vb) begin
        vb_n++;
        if (vb_k == 0) vb_k = k;
      end
      if (!t_vs) begin
        vs_n++;
        if (vs_f == 0) vs_f = k;
      end
      if (p_vs) pvs_n++;
      if (t_fs) begin
        fs_k = k;
        break;
      end
    end
    chk("fs_latency", fs_k, 96);
    chk("fs_cnt", t_fc, 1);
    chk("fs_xy", {t_x, t_y}, 0);
    chk("vb_latency", vb_k, 48);
    chk("vb_count", vb_n, 1);
    chk("vs_len", vs_n, 24);
    chk("vs_first", vs_f, 63);
    chk("pvs_len", pvs_n, 24);

    step(1'b0, 1'b0);
    chk("fs_drop", t_fs, 0);
    chk("fs_hold_x", t_x, 0);
    chk("fs_hold_cnt", t_fc, 1);

    // Alternate en; events must still last a single clock.
    n = 0; fs_n = 0; vb_n = 0;
    hold_bad = 0; pos_bad = 0;
    for (int i = 0; i < 192; i++) begin
      pb = t_bl; ph = t_hs; pv = t_vs;
      step(1'b0, (i % 2) == 0);
      if ((i % 2) == 0) begin
        n++;
        if (t_fs) fs_n++;
        if (t_vb) vb_n++;
      end else begin
        if (t_fs || t_vb) hold_bad++;
        if (t_bl != pb || t_hs != ph) hold_bad++;
        if (t_vs != pv) hold_bad++;
      end
      if (t_x != 5'(n % 12)) pos_bad++;
      if (t_y != 5'((n / 12) % 8)) pos_bad++;
    end
    chk("tog_hold", hold_bad, 0);
    chk("tog_pos", pos_bad, 0);
    chk("tog_fs", fs_n, 1);
    chk("tog_vb", vb_n, 1);
    chk("tog_cnt", t_fc, 2);

    // Reset mid-frame inside the vsync band.
    for (int i = 0; i < 66; i++) step(1'b0, 1'b1);
    chk("mid_x", t_x, 6);
    chk("mid_y", t_y, 5);
    chk("mid_vs", t_vs, 0);
    step(1'b1, 1'b0);
    chk("rst_x", t_x, 0);
    chk("rst_y", t_y, 0);
    chk("rst_cnt", t_fc, 0);
    chk("rst_blank", t_bl, 1);
    chk("rst_de", t_de, 0);
    chk("rst_hs", t_hs, 1);
    chk("rst_vs", t_vs, 1);
    chk("rst_fs", t_fs, 0);
    chk("rst_pvs", p_vs, 0);

    // Frame counter wrap.
    step(1'b0, 1'b1);
    force dut_t.frame_q = 16'hffff;
    step(1'b0, 1'b1);
    release dut_t.frame_q;
    chk("wrap_pre", t_fc, 65535);
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step(1'b0, 1'b1);
      if (t_fs) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wrap_seen", seen, 1);
    chk("wrap_cnt", t_fc, 0);

    // Default-size line timing on line 10.
    step(1'b1, 1'b0);
    chk("m_rst_xy", {m_x, m_y}, 0);
    chk("m_rst_blank", m_bl, 1);
    chk("m_rst_de", m_de, 0);
    chk("m_rst_hs", m_hs, 1);
    chk("m_rst_vs", m_vs, 1);
    chk("m_rst_fs", m_fs, 0);
    chk("m_rst_cnt", m_fc, 0);
    hn = 0; hf = -1; hl = -1; den = 0;
    rise = -1; fall = -1; pb = 1'b1;
    for (int k = 1; k <= 8802; k++) begin
      pb = m_bl;
      step(1'b0, 1'b1);
      if (k == 8000) begin
        chk("m_line_x", m_x, 0);
        chk("m_line_y", m_y, 10);
      end
      if (k >= 8000 && k < 8800) begin
        if (!m_hs) begin
          hn++;
          if (hf < 0) hf = int'(m_x);
          hl = int'(m_x);
        end
        if (m_de) den++;
        if (m_bl && !pb && rise < 0) rise = int'(m_x);
      end
      if (k >= 8000 && !m_bl && pb && fall < 0) fall = int'(m_x);
    end
    chk("m_hs_len", hn, 96);
    chk("m_hs_first", hf, 658);
    chk("m_hs_last", hl, 753);
    chk("m_de_len", den, 640);
    chk("m_blank_rise", rise, 642);
    chk("m_blank_fall", fall, 2);
    chk("m_vs_idle", m_vs, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised VGA/video timing generator and the successor to the fixed 640x480 timing block. It adds a pixel clock enable, configurable sync polarity, and a pipeline-delay compensation line that aligns sync/blank/de with downstream pixel-pipeline latency. It also provides frame and vblank event pulses plus a frame counter. It sits between the pixel clock domain and the framebuffer/renderer and VGA output pins, and its event pulses drive the MicroBlaze game-tick interrupt.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT_PORCH, 16, pixels
H_SYNC_PULSE, 96, pixels
H_BACK_PORCH, 48, pixels
V_VISIBLE, 480, active lines
V_FRONT_PORCH, 10, lines
V_SYNC_PULSE, 2, lines
V_BACK_PORCH, 33, lines
H_POL, 0, h_sync level during pulse (0 = active-low)
V_POL, 0, v_sync level during pulse
PIPE_DELAY, 2, en-cycles of delay from x/y to sync/blank/de; legal 1..8
CNT_W, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel-domain clock
rst  in  1  synchronous, active-high reset
en  in  1  pixel clock enable; all state advances only when 1
x  out  CNT_W  current horizontal count
y  out  CNT_W  current vertical count
h_sync  out  1  delayed horizontal sync, polarity H_POL
v_sync  out  1  delayed vertical sync, polarity V_POL
blank  out  1  delayed blanking (1 = outside visible area)
de  out  1  delayed data enable, always ~blank
frame_start  out  1  one-clk pulse at (0,0)
vblank_start  out  1  one-clk pulse at (0,V_VISIBLE)
frame_cnt  out  16  frames completed, wrapping

Behaviour:
- Reset is synchronous, active-high, on clk; clock is clk.
- Totals: H_TOTAL = sum of the four H parameters (800 at defaults); V_TOTAL = sum of the four V parameters (525 at defaults).
- Counters: on clk with en=1, x increments. When x = H_TOTAL-1, x goes to 0 and y increments. When y = V_TOTAL-1 at the same time, y goes to 0. With en=0, all registers hold.
- Raw decode from current x/y:
  - vis = (x < H_VISIBLE) && (y < V_VISIBLE)
  - hs = H_VISIBLE+H_FRONT_PORCH <= x < H_VISIBLE+H_FRONT_PORCH+H_SYNC_PULSE
  - vs = V_VISIBLE+V_FRONT_PORCH <= y < V_VISIBLE+V_FRONT_PORCH+V_SYNC_PULSE
  - vs covers whole lines.
- Delay line: a PIPE_DELAY-stage shift register of {hs, vs, vis}, shifting only on en=1. Outputs come from the last stage:
  - h_sync = hs ? H_POL : ~H_POL
  - v_sync = vs ? V_POL : ~V_POL
  - blank = ~vis
  - de = vis
- Latency: outputs describe the coordinate shown on x/y PIPE_DELAY en-cycles earlier.
- frame_start: registered. It is 1 for exactly the clk cycle in which x/y first show (0,0) after a wrap, and 0 on every other cycle, including en=0 cycles.
- vblank_start: same rule at (0, V_VISIBLE).
- frame_cnt: increments on each frame_start cycle; wraps 65535 -> 0.
- Reset values:
  - x = 0, y = 0, frame_cnt = 0
  - all delay stages inactive: h_sync = ~H_POL, v_sync = ~V_POL, blank = 1, de = 0
  - frame_start = 0, vblank_start = 0
  - reset does not produce a frame_start.
- Reset mid-frame takes effect on the next clk regardless of en; the delay line is flushed to inactive values.
- The first frame_start after reset occurs at the first wrap to (0,0).
- Width: counter compares are unsigned at CNT_W bits. frame_cnt is 16-bit modular.

Test Plan:
- rst=1 then en=1 continuously -> x runs 0..799, y increments on each x wrap; frame_start pulses exactly 420000 clks after reset release, with frame_cnt = 1 in the same cycle.
- Defaults (PIPE_DELAY=2), line y=10 -> h_sync=0 while x shows 658..753, else 1; blank rises when x shows 642 and falls when x shows 2; de=1 for 640 clks per visible line.
- v_sync -> 0 only across lines whose delayed coordinate has y in 490..491. Rerun with H_POL=1, V_POL=1 -> both sync outputs inverted, same timing.
- en toggled 1,0,1,0 -> x advances once per two clks; outputs hold on en=0 cycles. frame_start and vblank_start stay high exactly one clk even when followed by en=0.
- rst pulsed at x=300, y=200 with frame_cnt=5 -> next clk: x=0, y=0, frame_cnt=0, blank=1, de=0, h_sync=v_sync=1, frame_start=0.
- Continuous run -> vblank_start when x/y show (0,480), once per frame. Force frame_cnt to 65535 -> next frame_start gives 0.
